// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_t;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_rx_state_t;
`endif

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream: valid/ready handshake plus status and error pulses.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output rx_busy,
    output frame_err,
    output parity_err,
    output overrun
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  rx_busy,
    input  frame_err,
    input  parity_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_baud_cnt.sv
// Per-bit baud counter: ticks at the full or half bit period and restarts on each tick.
module uart_rx_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == (half ? HALF_TC : FULL_TC));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined), mid-bit sampling,
// one-byte holding register on a valid/ready interface, single-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  uart_rx_if.master  rx
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  uart_rx_state_t       state_q, state_d;
  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 line, fall, tick;

  assign line = sync_q[1];
  assign fall = prev_q && !line;

  // Synchronizer and edge-detect flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
      prev_q <= line;
    end
  end

  uart_rx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == StIdle),
    .half (state_q == StStart),
    .tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, pe_q, pe_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    if (valid_q && rx.rx_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          idx_d   = '0;
          state_d = line ? StIdle : StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          par_bad_d = line ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          if (!line) begin
            fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            pe_d = 1'b1;
`endif
          end else if (!valid_q || rx.rx_ready) begin
            // A load wins over a same-cycle accept.
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
    end
  end
  assign rx.parity_err = pe_q;
`else
  assign rx.parity_err = 1'b0;
`endif

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_busy   = (state_q != StIdle);
  assign rx.frame_err = fe_q;
  assign rx.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; frame outcomes predicted from line-level rules.
module tb_uart_rx;

  localparam int unsigned C = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rx_serial;

  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_serial(rx_serial),
    .rx       (bus)
  );

  int total = 0;
  int bad   = 0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int n_fe = 0, n_pe = 0, n_ov = 0;
  int e_fe = 0, e_pe = 0, e_ov = 0;
  bit exp_full = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    if (bus.frame_err)  n_fe++;
    if (bus.parity_err) n_pe++;
    if (bus.overrun)    n_ov++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame and records what a correct receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip);
    logic [10:0] bits;
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (PAR_EN) begin
      bits[9]  = (^d) ^ par_flip;
      bits[10] = stop;
      n = 11;
    end else begin
      bits[9] = stop;
      n = 10;
    end
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      rx_serial = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx_serial = 1'b1;
    repeat (C / 2) @(posedge clk);
    #1;
    if (!stop) e_fe++;
    else if (PAR_EN && par_flip) e_pe++;
    else if (exp_full && !bus.rx_ready) e_ov++;
    else begin
      exp_q.push_back(d);
      if (!bus.rx_ready) exp_full = 1'b1;
    end
  endtask

  task automatic flush(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_frame_err"}, n_fe, e_fe);
    check({tag, "_parity_err"}, n_pe, e_pe);
    check({tag, "_overrun"}, n_ov, e_ov);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit busy_seen;
    logic [7:0] d;
    rst_n = 1'b0;
    rx_serial = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.rx_valid, 0);
    check("rst_data", bus.rx_data, 0);
    check("rst_busy", bus.rx_busy, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    flush("good");
    check("good_busy_idle", bus.rx_busy, 0);

    // Start glitch
    busy_seen = 1'b0;
    @(posedge clk); #1;
    rx_serial = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.rx_busy) busy_seen = 1'b1;
      if (i == 4) rx_serial = 1'b1;
    end
    check("glitch_busy_rose", busy_seen, 1);
    check("glitch_busy_fell", bus.rx_busy, 0);
    flush("glitch");

    // Framing error, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_no_valid", bus.rx_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    flush("ferr");

    // Overrun
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_valid_held", bus.rx_valid, 1);
    check("ovr_data_held", bus.rx_data, exp_q[0]);
    check("ovr_pulse", n_ov, e_ov);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    exp_full = 1'b0;
    check("ovr_valid_cleared", bus.rx_valid, 0);
    flush("ovr");
    bus.rx_ready = 1'b1;

    if (PAR_EN) begin
      send_frame(8'h01, 1'b1, 1'b1);
      check("par_no_valid", bus.rx_valid, 0);
      send_frame(8'h01, 1'b1, 1'b0);
      flush("parity");
    end

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0));
    end
    flush("rand");

    // Reset in the middle of data bit 3
    d = 8'h6B;
    @(posedge clk); #1;
    rx_serial = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx_serial = d[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx_serial = d[3];
    repeat (C / 2) @(posedge clk);
    #3;
    check("mid_busy_before_rst", bus.rx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.rx_valid, 0);
    check("mid_rst_data", bus.rx_data, 0);
    check("mid_rst_busy", bus.rx_busy, 0);
    check("mid_rst_errs", {bus.frame_err, bus.parity_err, bus.overrun}, 0);
    rx_serial = 1'b1;
    exp_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(8'hFF, 1'b1, 1'b0);
    flush("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
